// File: rtl/pipelined_modulo_adder_if.sv
// pipelined_modulo_adder_if: operand/result handshake bundle for the modulo adder
interface pipelined_modulo_adder_if #(
   parameter int WIDTH = 7
);
   logic in_valid, in_ready, out_valid, out_ready, wrap, op_err;
   logic [WIDTH-1:0] a, b, k, sum;
   modport master (
      output in_valid, a, b, k, out_ready,
      input  in_ready, out_valid, sum, wrap, op_err
   );
   modport slave (
      input  in_valid, a, b, k, out_ready,
      output in_ready, out_valid, sum, wrap, op_err
   );
endinterface

// File: rtl/pipelined_modulo_adder.sv
// pipelined_modulo_adder: 3-stage (a + b) mod (2^WIDTH - k) with a global valid/ready stall
module pipelined_modulo_adder #(
   parameter int WIDTH = 7,
   parameter int STAGES = 3
) (
   input logic clk,
   input logic rst_n,
   pipelined_modulo_adder_if.slave bus
);
   localparam int N = WIDTH + 1;
   function automatic logic [N-1:0] prefix(input logic [N-1:0] g_in, input logic [N-1:0] p_in);
      logic [N-1:0] g, p, gn, pn;
      g = g_in;
      p = p_in;
      for (int d = 1; d < N; d = d * 2) begin
         gn = g;
         pn = p;
         for (int i = d; i < N; i++) begin
            gn[i] = g[i] | (p[i] & g[i-d]);
            pn[i] = p[i] & p[i-d];
         end
         g = gn;
         p = pn;
      end
      return g;
   endfunction
   logic [STAGES-1:0] vld;
   logic [N-1:0] a_x, b_x, k_x, m, cs_s, cs_c;
   logic [N-1:0] g1, p1, h1, gk1, pk1, hk1;
   logic [N-1:0] c2, h2, ck2, hk2, s_ab, s_k;
   logic [WIDTH-1:0] sum_q;
   logic e1, e2, w3, wrap_q, err_q;
   assign a_x = {1'b0, bus.a};
   assign b_x = {1'b0, bus.b};
   assign k_x = {1'b0, bus.k};
   assign m = (N'(1) << WIDTH) - k_x;
   assign cs_s = a_x ^ b_x ^ k_x;
   assign cs_c = {(bus.a & bus.b) | (bus.a & bus.k) | (bus.b & bus.k), 1'b0};
   assign s_ab = h2 ^ {c2[N-2:0], 1'b0};
   assign s_k = hk2 ^ {ck2[N-2:0], 1'b0};
   // a+b >= 2^WIDTH implies a+b+k >= 2^WIDTH, so the a+b overflow can only reinforce wrap
   assign w3 = s_k[WIDTH] | ck2[WIDTH] | s_ab[WIDTH] | c2[WIDTH];
   assign bus.in_ready = bus.out_ready | ~vld[STAGES-1];
   assign bus.out_valid = vld[STAGES-1];
   assign bus.sum = sum_q;
   assign bus.wrap = wrap_q;
   assign bus.op_err = err_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         {g1, p1, h1, gk1, pk1, hk1, e1} <= '0;
         {c2, h2, ck2, hk2, e2} <= '0;
         {sum_q, wrap_q, err_q} <= '0;
      end else if (bus.in_ready) begin
         vld <= {vld[STAGES-2:0], bus.in_valid};
         g1 <= a_x & b_x;
         p1 <= a_x | b_x;
         h1 <= a_x ^ b_x;
         gk1 <= cs_s & cs_c;
         pk1 <= cs_s | cs_c;
         hk1 <= cs_s ^ cs_c;
         e1 <= (a_x >= m) | (b_x >= m);
         c2 <= prefix(g1, p1);
         h2 <= h1;
         ck2 <= prefix(gk1, pk1);
         hk2 <= hk1;
         e2 <= e1;
         sum_q <= w3 ? s_k[WIDTH-1:0] : s_ab[WIDTH-1:0];
         wrap_q <= w3;
         err_q <= e2;
      end
   end
endmodule
